// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: derives MCLK/SCLK/LRCK from the system clock,
// pulls stereo pairs from the mixer over valid/ready and serialises them
// as Philips I2S (MSB one SCLK after the LRCK edge, 32-bit slots).
module i2s_tx_sequencer #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned MCLK_DIV = 8,
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              underrun_clr,
  output logic              mclk,
  output logic              sclk,
  output logic              lrck,
  output logic              sdata,
  output logic              frame_tick,
  output logic              underrun
);

  localparam int unsigned DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [5:0]          bit_q, bit_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0]   frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic                underrun_d;
  logic                handshake, boundary;

  logic                run_d;
  logic                s_ready_d, mclk_d, sclk_d, lrck_d, sdata_d, frame_tick_d;
  logic [4:0]          slot;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   chan;

  // Next-state logic: sequencing, counters, holding/frame registers, underrun flag
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    underrun_d  = underrun & ~underrun_clr;
    handshake   = s_valid & s_ready;
    boundary    = (state_q == RUN) && (div_q == DIV_LAST) && (bit_q == 6'd63);

    if (!en) begin
      // Abandon any frame in progress; underrun survives.
      state_d     = IDLE;
      div_d       = '0;
      bit_d       = '0;
      hold_full_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = PRIME;
        PRIME: begin
          if (handshake) begin
            frame_l_d = s_left;
            frame_r_d = s_right;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            bit_d = bit_q + 6'd1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          if (handshake) begin
            hold_l_d    = s_left;
            hold_r_d    = s_right;
            hold_full_d = 1'b1;
          end
          // s_ready is low whenever hold is full, so a boundary handshake
          // only ever lands in an empty hold and plays one frame later.
          if (boundary) begin
            if (hold_full_q) begin
              frame_l_d   = hold_l_q;
              frame_r_d   = hold_r_q;
              hold_full_d = 1'b0;
            end else begin
              frame_l_d  = '0;
              frame_r_d  = '0;
              underrun_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from next-cycle values so every pin is a plain flop
  always_comb begin
    run_d        = (state_d == RUN);
    slot         = bit_d[4:0];
    chan         = bit_d[5] ? frame_r_d : frame_l_d;
    idx          = IDX_W'(DATA_W - 32'(slot));
    mclk_d       = run_d && ((32'(div_d) % MCLK_DIV) >= (MCLK_DIV / 2));
    sclk_d       = run_d && (32'(div_d) >= (SCLK_DIV / 2));
    lrck_d       = run_d && bit_d[5];
    sdata_d      = run_d && (slot != 5'd0) && (32'(slot) <= DATA_W) && chan[idx];
    frame_tick_d = run_d && (div_d == DIV_LAST) && (bit_d == 6'd63);
    s_ready_d    = (state_d == PRIME) || (run_d && !hold_full_d);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      underrun    <= 1'b0;
      s_ready     <= 1'b0;
      mclk        <= 1'b0;
      sclk        <= 1'b0;
      lrck        <= 1'b0;
      sdata       <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      underrun    <= underrun_d;
      s_ready     <= s_ready_d;
      mclk        <= mclk_d;
      sclk        <= sclk_d;
      lrck        <= lrck_d;
      sdata       <= sdata_d;
      frame_tick  <= frame_tick_d;
    end
  end

endmodule
